change_dispenser: RTL and testbench

Pays out the change value produced by the vending FSM as a sequence of physical coin-eject requests toward the coin mechanism. Uses greedy selection (5, 2, 1 units) against per-denomination stock counters, with a req/ack handshake per coin, ack timeout and a latched fault. It sits between the vending FSM's `cambio` output and the coin-hopper interface pins.

---
 rtl/change_dispenser.sv | 142 ++++++++++++++
 tb/tb_change_dispenser.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as greedy 5/2/1 coin-eject requests,
// one req/ack handshake per coin, with stock tracking, ack timeout and a latched fault.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned STOCK_INIT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cambio,
  input  logic       cambio_valid,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic       fault_clr,
  output logic       coin_req,
  output logic [1:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_1     = 2'b01;
  localparam logic [1:0] COIN_2     = 2'b10;
  localparam logic [1:0] COIN_5     = 2'b11;
  localparam logic [3:0] STOCK_FULL = 4'(STOCK_INIT);
  localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_remaining;
  logic [1:0] r_sel;
  logic [3:0] r_s5;
  logic [3:0] r_s2;
  logic [3:0] r_s1;
  logic [7:0] r_timer;

  logic [1:0] w_pick;
  logic [3:0] w_sel_value;

  // Largest denomination that fits the outstanding amount and is still in stock.
  always_comb begin
    // NOTE: default first so every path assigns w_pick and no latch is inferred.
    w_pick = COIN_NONE;
    if (r_remaining >= 4'd5 && r_s5 != 4'd0) begin
      w_pick = COIN_5;
    end else if (r_remaining >= 4'd2 && r_s2 != 4'd0) begin
      w_pick = COIN_2;
    end else if (r_remaining != 4'd0 && r_s1 != 4'd0) begin
      w_pick = COIN_1;
    end
  end

  always_comb begin
    case (r_sel)
      COIN_5:  w_sel_value = 4'd5;
      COIN_2:  w_sel_value = 4'd2;
      COIN_1:  w_sel_value = 4'd1;
      default: w_sel_value = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= 4'd0;
      r_sel       <= COIN_NONE;
      r_s5        <= STOCK_FULL;
      r_s2        <= STOCK_FULL;
      r_s1        <= STOCK_FULL;
      r_timer     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cambio_valid) begin
            r_remaining <= cambio;
            r_state     <= (cambio != 4'd0) ? S_SELECT : S_DONE;
          end else if (refill) begin
            r_s5 <= STOCK_FULL;
            r_s2 <= STOCK_FULL;
            r_s1 <= STOCK_FULL;
          end
        end
        S_SELECT: begin
          if (r_remaining == 4'd0) begin
            r_state <= S_DONE;
          end else if (w_pick != COIN_NONE) begin
            r_sel   <= w_pick;
            r_timer <= 8'd0;
            r_state <= S_REQ;
          end else begin
            r_state <= S_FAULT;
          end
        end
        S_REQ: begin
          // An ack on the timeout cycle still wins and the coin counts.
          if (coin_ack) begin
            r_remaining <= r_remaining - w_sel_value;
            case (r_sel)
              COIN_5:  r_s5 <= r_s5 - 4'd1;
              COIN_2:  r_s2 <= r_s2 - 4'd1;
              COIN_1:  r_s1 <= r_s1 - 4'd1;
              default: ;
            endcase
            r_state <= S_GAP;
          end else begin
            r_timer <= r_timer + 8'd1;
            if (r_timer == TIMER_LAST) begin
              r_state <= S_FAULT;
            end
          end
        end
        S_GAP:  r_state <= S_SELECT;
        S_DONE: r_state <= S_IDLE;
        S_FAULT: begin
          if (fault_clr) begin
            r_remaining <= 4'd0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign coin_req  = (r_state == S_REQ);
  assign coin_out  = coin_req ? r_sel : COIN_NONE;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign fault     = (r_state == S_FAULT);
  assign remaining = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table, hand-written corner sequences and a
// randomized run scored against a greedy payout model with its own stock counts.
module tb_change_dispenser;

  typedef struct {
    logic [3:0] amt;
    int         n;
    logic [7:0] codes;  // coin i in bits [2i+1:2i]
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cambio = 4'd0;
  logic       cambio_valid = 1'b0;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic       fault_clr = 1'b0;

  logic       a_coin_req, a_busy, a_done, a_fault;
  logic [1:0] a_coin_out;
  logic [3:0] a_remaining;
  logic       b_coin_req, b_busy, b_done, b_fault;
  logic [1:0] b_coin_out;
  logic [3:0] b_remaining;

  logic       sel_b = 1'b0;
  logic       m_coin_req, m_busy, m_done, m_fault;
  logic [1:0] m_coin_out;
  logic [3:0] m_remaining;

  int n_checks = 0;
  int n_pass   = 0;
  int got_q[$];
  int rem_q[$];
  int exp_q[$];
  bit got_done, got_fault, exp_fault;
  int exp_rem;
  int ms5, ms2, ms1;
  vec_t vecs[8];

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .cambio(cambio), .cambio_valid(cambio_valid),
    .coin_ack(coin_ack), .refill(refill), .fault_clr(fault_clr),
    .coin_req(a_coin_req), .coin_out(a_coin_out), .busy(a_busy),
    .done(a_done), .fault(a_fault), .remaining(a_remaining)
  );

  change_dispenser #(.ACK_TIMEOUT(15), .STOCK_INIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cambio(cambio), .cambio_valid(cambio_valid),
    .coin_ack(coin_ack), .refill(refill), .fault_clr(fault_clr),
    .coin_req(b_coin_req), .coin_out(b_coin_out), .busy(b_busy),
    .done(b_done), .fault(b_fault), .remaining(b_remaining)
  );

  assign m_coin_req  = sel_b ? b_coin_req  : a_coin_req;
  assign m_coin_out  = sel_b ? b_coin_out  : a_coin_out;
  assign m_busy      = sel_b ? b_busy      : a_busy;
  assign m_done      = sel_b ? b_done      : a_done;
  assign m_fault     = sel_b ? b_fault     : a_fault;
  assign m_remaining = sel_b ? b_remaining : a_remaining;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Outputs are looked at 1 ns after the edge; inputs set here are taken at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " coin_req"},  m_coin_req,  0);
    check({tag, " coin_out"},  m_coin_out,  0);
    check({tag, " busy"},      m_busy,      0);
    check({tag, " done"},      m_done,      0);
    check({tag, " fault"},     m_fault,     0);
    check({tag, " remaining"}, m_remaining, 0);
  endtask

  task automatic start(input logic [3:0] amt);
    cambio       = amt;
    cambio_valid = 1'b1;
    step();
    cambio_valid = 1'b0;
    cambio       = 4'd0;
  endtask

  // Runs the handshake until done or fault, acking each coin after 0..max_delay cycles.
  task automatic collect(input int max_delay);
    int cyc;
    logic [1:0] code;
    cyc = 0;
    got_q.delete();
    rem_q.delete();
    got_done  = 1'b0;
    got_fault = 1'b0;
    while (!got_done && !got_fault && cyc < 400) begin
      if (m_done) got_done = 1'b1;
      else if (m_fault) got_fault = 1'b1;
      else if (m_coin_req) begin
        code = m_coin_out;
        got_q.push_back(int'(code));
        repeat ($urandom_range(max_delay, 0)) begin
          step();
          cyc++;
        end
        check("coin_out stable while req", {m_coin_req, m_coin_out}, {1'b1, code});
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        cyc++;
        check("req low after ack", m_coin_req, 0);
        rem_q.push_back(int'(m_remaining));
      end else begin
        step();
        cyc++;
      end
    end
    check("payout finished", got_done | got_fault, 1);
  endtask

  // Greedy payout from the model's own stock counts; coin codes 3=5u, 2=2u, 1=1u.
  task automatic model_pay(input int amt);
    int rem;
    rem = amt;
    exp_q.delete();
    exp_fault = 1'b0;
    while (rem > 0) begin
      if (rem >= 5 && ms5 > 0) begin
        exp_q.push_back(3); rem -= 5; ms5--;
      end else if (rem >= 2 && ms2 > 0) begin
        exp_q.push_back(2); rem -= 2; ms2--;
      end else if (ms1 > 0) begin
        exp_q.push_back(1); rem -= 1; ms1--;
      end else begin
        exp_fault = 1'b1;
        break;
      end
    end
    exp_rem = rem;
  endtask

  task automatic compare_coins(input string tag);
    check({tag, " coin count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s coin %0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int cnt;
    int cyc;
    int amt;

    vecs[0] = '{4'd8,  3, 8'b00_01_10_11};
    vecs[1] = '{4'd15, 3, 8'b00_11_11_11};
    vecs[2] = '{4'd14, 4, 8'b10_10_11_11};
    vecs[3] = '{4'd4,  2, 8'b00_00_10_10};
    vecs[4] = '{4'd1,  1, 8'b00_00_00_01};
    vecs[5] = '{4'd6,  2, 8'b00_00_01_11};
    vecs[6] = '{4'd13, 4, 8'b01_10_11_11};
    vecs[7] = '{4'd9,  3, 8'b00_10_10_11};

    do_reset();
    check_reset_outputs("reset");

    // Fresh stock per vector, prompt acks.
    for (int v = 0; v < 8; v++) begin
      logic [7:0] codes;
      do_reset();
      start(vecs[v].amt);
      collect(0);
      codes = vecs[v].codes;
      check($sformatf("vec%0d done", v), got_done, 1);
      check($sformatf("vec%0d coin count", v), got_q.size(), vecs[v].n);
      for (int i = 0; i < got_q.size() && i < vecs[v].n; i++)
        check($sformatf("vec%0d coin %0d", v, i), got_q[i], codes[2*i +: 2]);
      step();
      check($sformatf("vec%0d busy after", v), m_busy, 0);
      check($sformatf("vec%0d done one cycle", v), m_done, 0);
    end

    // cambio=8: remaining walks 8 -> 3 -> 1 -> 0.
    do_reset();
    start(4'd8);
    check("c8 select busy", m_busy, 1);
    check("c8 select req", m_coin_req, 0);
    check("c8 latched", m_remaining, 8);
    collect(0);
    check("c8 rem steps", rem_q.size(), 3);
    if (rem_q.size() == 3) begin
      check("c8 rem0", rem_q[0], 3);
      check("c8 rem1", rem_q[1], 1);
      check("c8 rem2", rem_q[2], 0);
    end
    step();

    // Never ack: coin_req stays high exactly 15 cycles, then fault.
    do_reset();
    start(4'd3);
    check("to select req", m_coin_req, 0);
    step();
    check("to first req", m_coin_req, 1);
    check("to first coin", m_coin_out, 2'b10);
    cnt = 1;
    cyc = 0;
    while (m_coin_req && cyc < 40) begin
      step();
      cyc++;
      if (m_coin_req) cnt++;
    end
    check("to req cycles", cnt, 15);
    check("to fault", m_fault, 1);
    check("to coin_out", m_coin_out, 0);
    check("to remaining", m_remaining, 3);
    step();
    check("to fault held", m_fault, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("to clr fault", m_fault, 0);
    check("to clr remaining", m_remaining, 0);
    check("to clr busy", m_busy, 0);

    // Ack on the 15th REQ cycle wins over the timeout.
    do_reset();
    start(4'd1);
    step();
    repeat (14) step();
    check("race req", m_coin_req, 1);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    check("race no fault", m_fault, 0);
    check("race remaining", m_remaining, 0);
    step();
    check("race select", m_done, 0);
    step();
    check("race done", m_done, 1);
    step();

    // cambio=0: done right after the sample edge, busy for that cycle only.
    do_reset();
    start(4'd0);
    check("zero done", m_done, 1);
    check("zero busy", m_busy, 1);
    check("zero req", m_coin_req, 0);
    step();
    check("zero done drop", m_done, 0);
    check("zero busy drop", m_busy, 0);

    // cambio=7 with a second request and a stray ack in GAP.
    do_reset();
    start(4'd7);
    step();
    check("c7 first coin", m_coin_out, 2'b11);
    coin_ack = 1'b1;
    step();
    check("c7 gap rem", m_remaining, 2);
    coin_ack     = 1'b1;
    cambio_valid = 1'b1;
    cambio       = 4'd5;
    step();
    coin_ack     = 1'b0;
    cambio_valid = 1'b0;
    cambio       = 4'd0;
    check("c7 stray ignored", m_remaining, 2);
    collect(1);
    check("c7 rest count", got_q.size(), 1);
    if (got_q.size() == 1) check("c7 rest coin", got_q[0], 2);
    check("c7 done", got_done, 1);
    step();
    check("c7 idle", m_busy, 0);

    // Reset while in REQ abandons the payout.
    do_reset();
    start(4'd5);
    step();
    check("rst req", m_coin_req, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_outputs("rst mid");
    start(4'd1);
    collect(0);
    check("rst after count", got_q.size(), 1);
    if (got_q.size() == 1) check("rst after coin", got_q[0], 1);
    check("rst after done", got_done, 1);
    step();

    // One coin of each denomination in stock: 10 pays 5,2,1 then faults with 2 left.
    sel_b = 1'b1;
    do_reset();
    start(4'd10);
    collect(0);
    exp_q = '{3, 2, 1};
    compare_coins("s1");
    check("s1 fault", got_fault, 1);
    check("s1 remaining", m_remaining, 2);
    check("s1 req low", m_coin_req, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("s1 clr fault", m_fault, 0);
    check("s1 clr remaining", m_remaining, 0);
    check("s1 clr busy", m_busy, 0);
    refill = 1'b1;
    step();
    refill = 1'b0;
    start(4'd2);
    collect(0);
    exp_q = '{2};
    compare_coins("s1 refill");
    check("s1 refill done", got_done, 1);
    step();
    sel_b = 1'b0;

    // Randomized amounts, refills and ack delays against the greedy model.
    do_reset();
    ms5 = 8; ms2 = 8; ms1 = 8;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(3, 0) == 0) begin
        refill = 1'b1;
        step();
        refill = 1'b0;
        ms5 = 8; ms2 = 8; ms1 = 8;
      end
      amt = int'($urandom_range(15, 0));
      model_pay(amt);
      start(4'(amt));
      collect(3);
      compare_coins($sformatf("rnd%0d amt%0d", t, amt));
      check($sformatf("rnd%0d fault", t), got_fault, exp_fault);
      if (got_fault) begin
        if (exp_fault) check($sformatf("rnd%0d unpaid", t), m_remaining, exp_rem);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
      end else begin
        check($sformatf("rnd%0d done rem", t), m_remaining, 0);
        step();
      end
      check($sformatf("rnd%0d idle", t), m_busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
